fade_frame_rx: RTL and testbench
================================

# fade_frame_rx

AXI-Stream receiver for the 32-point frames emitted by the fade IFFT master port (tdata/tuser/tlast), sitting between the IFFT core and the window/interpolation stages. Each frame is written into one of two ping-pong banks at the address given by tuser, which undoes any output ordering of the core. The frame is checked for tlast placement and index integrity, then presented as a parallel 32-entry frame with a valid/ready handshake. Bad frames are dropped with one-cycle error pulses, and a resync state restores alignment after a missing tlast.

## Interface
- N_LOG2, 5, log2 of frame length N (N = 32)
- DW, 16, bits per real/imag component
- clk  in  1  single clock, all logic rising edge
- aresetn  in  1  asynchronous active-low reset
- s_axis_tdata  in  2*DW  {imag, real}
- s_axis_tuser  in  8  sample index in [N_LOG2-1:0]; upper bits ignored
- s_axis_tvalid  in  1  beat valid
- s_axis_tready  out  1  beat accepted when tvalid & tready
- s_axis_tlast  in  1  last beat of frame
- frame_valid  out  1  a complete good frame is presented
- frame_ready  in  1  consumer takes frame when frame_valid & frame_ready
- frame_real, frame_imag  out  N x DW  parallel frame; entry k = sample with index k
- err_tlast_unexpected  out  1  pulse: tlast before beat N
- err_tlast_missing  out  1  pulse: beat N without tlast
- err_index  out  1  pulse: frame completed with a duplicated index
- frame_count  out  16  good frames delivered, wraps 0xFFFF -> 0

## Operation
- Writer states: FILL and RESYNC. Beat counter cnt runs 0..N-1. Write-bank select is wr_sel. Each bank has a full flag and an N-bit written bitmap.
- FILL, accepted beat: store the beat in bank[wr_sel] at tuser index and set its bitmap bit. If the bit was already set, latch a dup flag.
- tlast at cnt < N-1: pulse err_tlast_unexpected, discard the partial frame (clear bitmap and dup), cnt <= 0, stay in FILL.
- cnt == N-1 with tlast: if dup, pulse err_index and discard. Otherwise set full[wr_sel], toggle wr_sel and increment frame_count. Either way clear bitmap and dup, and set cnt <= 0.
- cnt == N-1 without tlast: pulse err_tlast_missing, discard, go to RESYNC.
- RESYNC: tready = 1. Accepted beats are dropped. The first accepted beat with tlast returns the writer to FILL with cnt = 0; that beat is not stored.
- s_axis_tready = (state == RESYNC) | ~full[wr_sel]. It is combinational from registers only, with no dependence on tvalid.
- Reader: frame_valid = full[rd_sel]; frame_real/imag = bank[rd_sel]. On frame_valid & frame_ready, clear full[rd_sel] and toggle rd_sel.
- Bank storage is not reset. Frame data is don't-care while frame_valid = 0.

## Timing
- Reset values: s_axis_tready 1 once aresetn deasserts, frame_valid 0, all err_* 0, frame_count 0, state FILL, cnt 0, wr_sel = rd_sel = 0, full flags 0.
- Latency: last good beat accepted at edge t gives frame_valid = 1 and frame_count updated after edge t.
- Error pulses are registered: exactly one cycle high, on the cycle after the offending beat.
- Both banks full: tready = 0. After a consume at edge t, tready = 1 after edge t, with no bubble beyond that.
- Completing a frame in one bank and consuming the other bank on the same edge: both take effect; valid stays high.
- Index out of order but complete with no duplicates: accepted, and reordered by address.
- tvalid low mid-frame: state holds indefinitely.
- aresetn asserted mid-frame or with frames pending: all frames are lost and registers return to their reset values asynchronously.

## Structure
- Package fade_pkg: N_LOG2, N, DW, typedef sample_t {logic signed [DW-1:0] re, im}, typedef frame_t (sample_t [N-1:0]), enum rx_state_t {FILL, RESYNC}.
- Sub-module fade_frame_bank: one N-entry sample_t register bank with write enable/address, written bitmap, dup detect and clear. Instantiated twice.
- The top level holds the writer FSM, counters, full flags, read mux and error registers.

## Test plan
- 32 beats with index 0..31, real = k, imag = -k, tlast on beat 31, frame_ready = 1: frame_valid 1 for one cycle, frame_real[k] = k, frame_imag[k] = -k, frame_count = 1.
- Bit-reversed index order (0,16,8,24,...): frame_real[k] = k for all k, no errors.
- frame_ready = 0, three frames sent back-to-back: two frames buffered, tready drops after the second last beat. Asserting frame_ready resumes flow; frames are delivered in order with counts 1, 2, 3.
- tlast on beat 10, then a good frame: err_tlast_unexpected pulses once and only the good frame is delivered.
- 40 beats with tlast only on beat 40, then a good frame: err_tlast_missing after beat 32, beats 33-40 dropped, the good frame is delivered, frame_count = 1.
- Index 5 repeated (index 6 absent): err_index pulses after beat 32 and no frame_valid. Pulling aresetn low mid-frame gives frame_valid 0 and frame_count 0.

Source files
------------

// File: rtl/fade_frame_rx_pkg.sv
// -----------------------------------------------------------------------------
// fade_pkg
// Shared constants and types for the fade IFFT frame receiver.
//   N_LOG2 / N : frame length (32 points)
//   DW         : bits per real/imag component
//   UW         : width of the AXI-Stream tuser sample-index field
//   sample_t   : one complex sample {re, im}
//   frame_t    : N samples, entry k holds the sample with index k
//   rx_state_t : writer FSM states
// -----------------------------------------------------------------------------
package fade_pkg;

    localparam int unsigned N_LOG2 = 5;
    localparam int unsigned N      = 1 << N_LOG2;
    localparam int unsigned DW     = 16;
    localparam int unsigned UW     = 8;

    // Beat counter value of the final beat of a frame.
    localparam logic [N_LOG2-1:0] LAST_BEAT = N_LOG2'(N - 1);

    typedef struct packed {
        logic signed [DW-1:0] re;
        logic signed [DW-1:0] im;
    } sample_t;

    typedef sample_t [N-1:0] frame_t;

    typedef enum logic [0:0] {
        FILL   = 1'b0,
        RESYNC = 1'b1
    } rx_state_t;

    // tdata carries {imag, real}.
    function automatic sample_t unpack_tdata(input logic [2*DW-1:0] tdata);
        sample_t s;
        s.re = tdata[DW-1:0];
        s.im = tdata[2*DW-1:DW];
        return s;
    endfunction

endpackage

// File: rtl/fade_frame_rx_if.sv
// -----------------------------------------------------------------------------
// fade_frame_rx_if
// AXI-Stream link from the fade IFFT master port to the frame receiver.
//   tdata  : {imag, real}, 2*DW bits
//   tuser  : sample index in the low N_LOG2 bits, upper bits ignored
//   tvalid : beat valid (master)
//   tready : beat accepted when tvalid & tready (slave)
//   tlast  : last beat of a frame
// Modports: master (IFFT side), slave (receiver side).
// -----------------------------------------------------------------------------
interface fade_frame_rx_if;

    logic [2*fade_pkg::DW-1:0] tdata;
    logic [fade_pkg::UW-1:0]   tuser;
    logic                      tvalid;
    logic                      tready;
    logic                      tlast;

    modport master (
        output tdata,
        output tuser,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tuser,
        input  tvalid,
        input  tlast,
        output tready
    );

endinterface

// File: rtl/fade_frame_bank.sv
// -----------------------------------------------------------------------------
// fade_frame_bank
// One N-entry sample buffer of the ping-pong pair. Tracks which entries have
// been written in the current frame and flags a duplicated index.
// Ports:
//   clk, aresetn : clock, asynchronous active-low reset
//   we           : write wdata at waddr this cycle
//   waddr        : sample index
//   wdata        : sample to store
//   clr          : end of frame, clear bitmap and dup flag (wins over we)
//   rdata        : whole buffered frame
//   dup_now      : duplicate seen in this frame, including the current write
// -----------------------------------------------------------------------------
module fade_frame_bank
    import fade_pkg::*;
(
    input  logic              clk,
    input  logic              aresetn,
    input  logic              we,
    input  logic [N_LOG2-1:0] waddr,
    input  sample_t           wdata,
    input  logic              clr,
    output frame_t            rdata,
    output logic              dup_now
);

    frame_t          mem_q;
    logic [N-1:0]    bitmap_q, bitmap_d;
    logic            dup_q, dup_d;

    // Sample storage is deliberately not reset; it is only observed while
    // the owning full flag is set.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_comb begin
        // The final beat of a frame must see its own collision, so the
        // combinational view is exported rather than the registered flag.
        dup_now  = dup_q | (we & bitmap_q[waddr]);
        bitmap_d = bitmap_q;
        dup_d    = dup_now;
        if (we) begin
            bitmap_d[waddr] = 1'b1;
        end
        if (clr) begin
            bitmap_d = '0;
            dup_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            bitmap_q <= '0;
            dup_q    <= 1'b0;
        end else begin
            bitmap_q <= bitmap_d;
            dup_q    <= dup_d;
        end
    end

    assign rdata = mem_q;

endmodule

// File: rtl/fade_frame_rx.sv
// -----------------------------------------------------------------------------
// fade_frame_rx
// Receives 32-point frames from the fade IFFT over AXI-Stream, writes each
// beat into a ping-pong bank at its tuser index (undoing output ordering),
// checks tlast placement and index uniqueness, and presents good frames in
// parallel with a valid/ready handshake.
// Ports:
//   clk, aresetn         : clock, asynchronous active-low reset
//   s_axis               : AXI-Stream slave (tdata/tuser/tvalid/tready/tlast)
//   frame_valid          : a complete good frame is presented
//   frame_ready          : consumer takes the frame on valid & ready
//   frame_real/imag      : entry k = component of sample with index k
//   err_tlast_unexpected : one-cycle pulse, tlast before beat N
//   err_tlast_missing    : one-cycle pulse, beat N without tlast
//   err_index            : one-cycle pulse, frame had a duplicated index
//   frame_count          : good frames completed, wraps at 16 bits
// -----------------------------------------------------------------------------
module fade_frame_rx
    import fade_pkg::*;
(
    input  logic                clk,
    input  logic                aresetn,
    fade_frame_rx_if.slave      s_axis,
    output logic                frame_valid,
    input  logic                frame_ready,
    output logic [N-1:0][DW-1:0] frame_real,
    output logic [N-1:0][DW-1:0] frame_imag,
    output logic                err_tlast_unexpected,
    output logic                err_tlast_missing,
    output logic                err_index,
    output logic [15:0]         frame_count
);

    rx_state_t         state_q, state_d;
    logic [N_LOG2-1:0] cnt_q, cnt_d;
    logic              wr_sel_q, wr_sel_d;
    logic              rd_sel_q, rd_sel_d;
    logic [1:0]        full_q, full_d;
    logic [15:0]       count_q, count_d;
    logic              err_unexp_q, err_unexp_d;
    logic              err_miss_q, err_miss_d;
    logic              err_idx_q, err_idx_d;

    logic              tready;
    logic              accept;
    logic              wr_we;
    logic              wr_clr;
    logic              cur_dup;
    logic [N_LOG2-1:0] waddr;
    sample_t           wdata;
    frame_t            bank_rdata [2];
    logic              bank_dup   [2];
    frame_t            rd_frame;

    // Index bits above N_LOG2 carry no meaning for this frame size.
    logic unused_tuser;
    assign unused_tuser = ^s_axis.tuser[UW-1:N_LOG2];

    assign waddr = s_axis.tuser[N_LOG2-1:0];
    assign wdata = unpack_tdata(s_axis.tdata);

    // tready depends on registers only, never on tvalid.
    assign tready        = (state_q == RESYNC) | ~full_q[wr_sel_q];
    assign s_axis.tready = tready;
    assign accept        = s_axis.tvalid & tready;
    assign cur_dup       = bank_dup[wr_sel_q];

    for (genvar b = 0; b < 2; b++) begin : g_bank
        fade_frame_bank u_bank (
            .clk     (clk),
            .aresetn (aresetn),
            .we      (wr_we & (wr_sel_q == 1'(b))),
            .waddr   (waddr),
            .wdata   (wdata),
            .clr     (wr_clr & (wr_sel_q == 1'(b))),
            .rdata   (bank_rdata[b]),
            .dup_now (bank_dup[b])
        );
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_sel_d    = wr_sel_q;
        rd_sel_d    = rd_sel_q;
        full_d      = full_q;
        count_d     = count_q;
        err_unexp_d = 1'b0;
        err_miss_d  = 1'b0;
        err_idx_d   = 1'b0;
        wr_we       = 1'b0;
        wr_clr      = 1'b0;

        // Reader: hand over the bank at rd_sel and move on.
        if (full_q[rd_sel_q] && frame_ready) begin
            full_d[rd_sel_q] = 1'b0;
            rd_sel_d         = ~rd_sel_q;
        end

        // Writer. A set here never targets the bank the reader is clearing:
        // writing requires full[wr_sel] = 0, reading requires full[rd_sel] = 1.
        unique case (state_q)
            FILL: begin
                if (accept) begin
                    wr_we = 1'b1;
                    if (s_axis.tlast && (cnt_q != LAST_BEAT)) begin
                        err_unexp_d = 1'b1;
                        wr_clr      = 1'b1;
                        cnt_d       = '0;
                    end else if (cnt_q == LAST_BEAT) begin
                        wr_clr = 1'b1;
                        cnt_d  = '0;
                        if (s_axis.tlast) begin
                            if (cur_dup) begin
                                err_idx_d = 1'b1;
                            end else begin
                                full_d[wr_sel_q] = 1'b1;
                                wr_sel_d         = ~wr_sel_q;
                                count_d          = count_q + 16'd1;
                            end
                        end else begin
                            err_miss_d = 1'b1;
                            state_d    = RESYNC;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            RESYNC: begin
                // Drop everything up to and including the next tlast.
                if (accept && s_axis.tlast) begin
                    state_d = FILL;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = FILL;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= FILL;
            cnt_q       <= '0;
            wr_sel_q    <= 1'b0;
            rd_sel_q    <= 1'b0;
            full_q      <= '0;
            count_q     <= '0;
            err_unexp_q <= 1'b0;
            err_miss_q  <= 1'b0;
            err_idx_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_sel_q    <= wr_sel_d;
            rd_sel_q    <= rd_sel_d;
            full_q      <= full_d;
            count_q     <= count_d;
            err_unexp_q <= err_unexp_d;
            err_miss_q  <= err_miss_d;
            err_idx_q   <= err_idx_d;
        end
    end

    assign rd_frame = bank_rdata[rd_sel_q];

    always_comb begin
        for (int k = 0; k < N; k++) begin
            frame_real[k] = rd_frame[k].re;
            frame_imag[k] = rd_frame[k].im;
        end
    end

    assign frame_valid          = full_q[rd_sel_q];
    assign frame_count          = count_q;
    assign err_tlast_unexpected = err_unexp_q;
    assign err_tlast_missing    = err_miss_q;
    assign err_index            = err_idx_q;

endmodule

// File: tb/tb_fade_frame_rx.sv
module tb_fade_frame_rx;
    import fade_pkg::*;

    logic clk = 1'b0;
    logic aresetn = 1'b0;
    logic frame_ready = 1'b0;
    logic frame_valid;
    logic [N-1:0][DW-1:0] frame_real, frame_imag;
    logic err_tlast_unexpected, err_tlast_missing, err_index;
    logic [15:0] frame_count;

    int n_checks = 0;
    int n_errors = 0;

    fade_frame_rx_if axis ();

    fade_frame_rx dut (
        .clk                  (clk),
        .aresetn              (aresetn),
        .s_axis               (axis),
        .frame_valid          (frame_valid),
        .frame_ready          (frame_ready),
        .frame_real           (frame_real),
        .frame_imag           (frame_imag),
        .err_tlast_unexpected (err_tlast_unexpected),
        .err_tlast_missing    (err_tlast_missing),
        .err_index            (err_index),
        .frame_count          (frame_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] bitrev(input int j);
        logic [4:0] v, r;
        v = 5'(j);
        for (int i = 0; i < 5; i++) r[i] = v[4-i];
        return r;
    endfunction

    function automatic logic [N-1:0][DW-1:0] exp_re(input int base);
        logic [N-1:0][DW-1:0] e;
        for (int k = 0; k < N; k++) e[k] = 16'(base + k);
        return e;
    endfunction

    function automatic logic [N-1:0][DW-1:0] exp_im(input int base);
        logic [N-1:0][DW-1:0] e;
        for (int k = 0; k < N; k++) e[k] = -16'(base + k);
        return e;
    endfunction

    // Present one beat at a negedge, hold until accepted, drop tvalid #1 after.
    task automatic send_beat(input int idx, input int val, input logic last);
        int n;
        logic [15:0] re;
        re = 16'(val);
        @(negedge clk);
        axis.tdata  = {-re, re};
        axis.tuser  = 8'(idx);
        axis.tlast  = last;
        axis.tvalid = 1'b1;
        n = 0;
        while (!axis.tready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            n_checks++;
            n_errors++;
            $error("FAIL tready_timeout: observed=0 expected=1");
        end else begin
            @(posedge clk);
        end
        #1;
        axis.tvalid = 1'b0;
        axis.tlast  = 1'b0;
    endtask

    // Full frame with value base+idx at index idx.
    task automatic send_frame(input int base, input bit rev);
        for (int j = 0; j < N; j++) begin
            int idx;
            idx = rev ? int'(bitrev(j)) : j;
            send_beat(idx, base + idx, j == N - 1);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        aresetn = 1'b0;
        repeat (2) @(negedge clk);
        aresetn = 1'b1;
    endtask

    initial begin
        axis.tdata  = '0;
        axis.tuser  = '0;
        axis.tvalid = 1'b0;
        axis.tlast  = 1'b0;
        repeat (2) @(negedge clk);
        aresetn = 1'b1;
        @(negedge clk);

        // Reset state
        check("rst_valid", frame_valid, 0);
        check("rst_count", frame_count, 0);
        check("rst_errs", {err_tlast_unexpected, err_tlast_missing, err_index}, 0);
        check("rst_tready", axis.tready, 1);

        // In-order frame, consumer ready
        frame_ready = 1'b1;
        send_frame(0, 0);
        check("f1_valid", frame_valid, 1);
        check("f1_count", frame_count, 1);
        check("f1_real", frame_real, exp_re(0));
        check("f1_imag", frame_imag, exp_im(0));
        @(posedge clk); #1;
        check("f1_valid_one_cycle", frame_valid, 0);

        // Bit-reversed arrival order
        send_frame(0, 1);
        check("rev_valid", frame_valid, 1);
        check("rev_count", frame_count, 2);
        check("rev_real", frame_real, exp_re(0));
        check("rev_errs", {err_tlast_unexpected, err_tlast_missing, err_index}, 0);
        @(posedge clk); #1;

        // Back-pressure: three frames, consumer stalled
        do_reset();
        frame_ready = 1'b0;
        send_frame(100, 0);
        check("bp_a_tready", axis.tready, 1);
        send_frame(200, 0);
        check("bp_both_full_tready", axis.tready, 0);
        check("bp_count2", frame_count, 2);
        check("bp_a_real", frame_real, exp_re(100));
        fork
            send_frame(300, 0);
            begin
                repeat (3) @(posedge clk);
                #1;
                check("bp_stall_tready", axis.tready, 0);
                @(negedge clk);
                frame_ready = 1'b1;
                @(posedge clk); #1;
                frame_ready = 1'b0;
                check("bp_after_consume_tready", axis.tready, 1);
                check("bp_b_real", frame_real, exp_re(200));
            end
        join
        check("bp_count3", frame_count, 3);
        check("bp_valid_held", frame_valid, 1);
        @(negedge clk);
        frame_ready = 1'b1;
        @(posedge clk); #1;
        frame_ready = 1'b0;
        check("bp_c_real", frame_real, exp_re(300));
        check("bp_c_imag", frame_imag, exp_im(300));
        @(negedge clk);
        frame_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_drained", frame_valid, 0);

        // Early tlast, then a good frame
        do_reset();
        for (int j = 0; j < 10; j++) send_beat(j, 50, j == 9);
        check("unexp_pulse", err_tlast_unexpected, 1);
        check("unexp_no_valid", frame_valid, 0);
        @(posedge clk); #1;
        check("unexp_pulse_end", err_tlast_unexpected, 0);
        send_frame(400, 0);
        check("unexp_good_count", frame_count, 1);
        check("unexp_good_real", frame_real, exp_re(400));
        @(posedge clk); #1;

        // Missing tlast: 40 beats with tlast on beat 40, then a good frame
        do_reset();
        for (int j = 0; j < 40; j++) begin
            send_beat(j % N, 7, j == 39);
            if (j == 31) check("miss_pulse", err_tlast_missing, 1);
            if (j == 32) check("miss_pulse_end", err_tlast_missing, 0);
        end
        check("miss_no_valid", frame_valid, 0);
        check("miss_count0", frame_count, 0);
        send_frame(500, 0);
        check("miss_good_valid", frame_valid, 1);
        check("miss_good_count", frame_count, 1);
        check("miss_good_real", frame_real, exp_re(500));
        @(posedge clk); #1;

        // Duplicated index 5 (index 6 absent)
        for (int j = 0; j < N; j++) send_beat((j == 6) ? 5 : j, 9, j == N - 1);
        check("dup_pulse", err_index, 1);
        check("dup_no_valid", frame_valid, 0);
        check("dup_count", frame_count, 1);
        @(posedge clk); #1;
        check("dup_pulse_end", err_index, 0);

        // Reset mid-frame with a frame pending
        frame_ready = 1'b0;
        send_frame(600, 0);
        check("pend_valid", frame_valid, 1);
        check("pend_count", frame_count, 2);
        for (int j = 0; j < 10; j++) send_beat(j, 1, 1'b0);
        #2;
        aresetn = 1'b0;
        #1;
        check("arst_valid", frame_valid, 0);
        check("arst_count", frame_count, 0);
        @(negedge clk);
        aresetn = 1'b1;
        check("arst_tready", axis.tready, 1);
        send_frame(700, 0);
        check("post_rst_count", frame_count, 1);
        check("post_rst_real", frame_real, exp_re(700));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
